// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one two-stage registered adder among NUM_REQ requesters.
// Results are tagged with the requester index and leave in grant order.
module adder_share_arbiter #(
    parameter int unsigned ADDER_WIDTH = 34,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_WIDTH    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ADDER_WIDTH:0]           rsp_sum,
    output logic [ID_WIDTH-1:0]            rsp_id
);

    localparam logic [ID_WIDTH-1:0] LastRst = ID_WIDTH'(NUM_REQ - 1);

    logic                   stall;
    logic [ID_WIDTH-1:0]    last_q;
    logic [NUM_REQ-1:0]     grant;
    logic                   grant_any;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [ADDER_WIDTH-1:0] grant_a;
    logic [ADDER_WIDTH-1:0] grant_b;

    logic                   s1_valid_q;
    logic [ADDER_WIDTH-1:0] s1_a_q;
    logic [ADDER_WIDTH-1:0] s1_b_q;
    logic [ID_WIDTH-1:0]    s1_id_q;

    logic                   rsp_valid_q;
    logic [ADDER_WIDTH:0]   rsp_sum_q;
    logic [ID_WIDTH-1:0]    rsp_id_q;

    assign stall = rsp_valid_q & ~rsp_ready;

    // Two passes give the rotation: first indices above last, then wrap to 0..last.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_a   = '0;
        grant_b   = '0;
        if (!stall) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!grant_any && req_valid[i] && (i > int'(last_q))) begin
                    grant_any = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = ID_WIDTH'(i);
                    grant_a   = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
                    grant_b   = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
                end
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!grant_any && req_valid[i] && (i <= int'(last_q))) begin
                    grant_any = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = ID_WIDTH'(i);
                    grant_a   = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
                    grant_b   = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
                end
            end
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= LastRst;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else if (!stall) begin
            s1_valid_q <= grant_any;
            if (grant_any) begin
                last_q  <= grant_idx;
                s1_a_q  <= grant_a;
                s1_b_q  <= grant_b;
                s1_id_q <= grant_idx;
            end
            rsp_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rsp_sum_q <= {1'b0, s1_a_q} + {1'b0, s1_b_q};
                rsp_id_q  <= s1_id_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: grant order, latency, overflow, backpressure, reset.
module tb_adder_share_arbiter;

    localparam int W = 34;
    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a = '0;
    logic [N*W-1:0]    req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [W:0]        rsp_sum;
    logic [1:0]        rsp_id;

    int vectors = 0;
    int errors  = 0;

    adder_share_arbiter #(
        .ADDER_WIDTH(W),
        .NUM_REQ    (N),
        .ID_WIDTH   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [W-1:0] abase, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = abase + W'(i);
            req_b[i*W +: W] = b;
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum} !== '0) begin
            errors++;
            $display("FAIL reset.rsp: got v=%b id=%0d sum=%h want all zero", rsp_valid, rsp_id, rsp_sum);
        end
        vectors++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset.req_ready: got %b want 0000", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset.priority: got %b want 0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_single();
        req_a[0 +: W] = W'(5);
        req_b[0 +: W] = W'(7);
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single.req_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single.early_valid: got %b want 0", rsp_valid);
        end
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 35'd12}) begin
            errors++;
            $display("FAIL single.rsp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=12",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single.clear: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_overflow();
        req_a[2*W +: W] = '1;
        req_b[2*W +: W] = '1;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL overflow.req_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd2, 35'h7FFFFFFFE}) begin
            errors++;
            $display("FAIL overflow.rsp: got v=%b id=%0d sum=%h want v=1 id=2 sum=7fffffffe",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] one = 4'b0001;
        apply_reset();
        set_ops(W'(0), W'(100));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            vectors++;
            if (req_ready !== (one << (c % 4))) begin
                errors++;
                $display("FAIL rr.grant[%0d]: got %b want %b", c, req_ready, one << (c % 4));
            end
            vectors++;
            if (c < 2) begin
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rr.fill[%0d]: got rsp_valid=%b want 0", c, rsp_valid);
                end
            end else if ({rsp_valid, rsp_id, rsp_sum} !==
                         {1'b1, 2'((c - 2) % 4), 35'(100 + (c - 2) % 4)}) begin
                errors++;
                $display("FAIL rr.rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                         c, rsp_valid, rsp_id, rsp_sum, (c - 2) % 4, 100 + (c - 2) % 4);
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        vectors++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr.drain: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_ready [12] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                       4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        int         exp_id [12] = '{-1, -1, 0, 0, 0, 0, 0, 0, 1, 2, 3, -1};
        set_ops(W'(10), W'(1));
        for (int c = 0; c < 12; c++) begin
            rsp_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            req_valid = (c <= 8) ? 4'b1111 : 4'b0000;
            #1;
            vectors++;
            if (req_ready !== exp_ready[c]) begin
                errors++;
                $display("FAIL bp.grant[%0d]: got %b want %b", c, req_ready, exp_ready[c]);
            end
            vectors++;
            if (exp_id[c] < 0) begin
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp.idle[%0d]: got rsp_valid=%b want 0", c, rsp_valid);
                end
            end else if ({rsp_valid, rsp_id, rsp_sum} !==
                         {1'b1, 2'(exp_id[c]), 35'(11 + exp_id[c])}) begin
                errors++;
                $display("FAIL bp.rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                         c, rsp_valid, rsp_id, rsp_sum, exp_id[c], 11 + exp_id[c]);
            end
            step();
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_sparse();
        logic [3:0] drv [7]       = '{4'b0010, 4'b1000, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] exp_ready [7] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        int         exp_id [7]    = '{-1, -1, 1, 3, 0, 1, -1};
        set_ops(W'(20), W'(0));
        for (int c = 0; c < 7; c++) begin
            req_valid = drv[c];
            #1;
            vectors++;
            if (req_ready !== exp_ready[c]) begin
                errors++;
                $display("FAIL sparse.grant[%0d]: got %b want %b", c, req_ready, exp_ready[c]);
            end
            vectors++;
            if (exp_id[c] < 0) begin
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL sparse.idle[%0d]: got rsp_valid=%b want 0", c, rsp_valid);
                end
            end else if ({rsp_valid, rsp_id, rsp_sum} !==
                         {1'b1, 2'(exp_id[c]), 35'(20 + exp_id[c])}) begin
                errors++;
                $display("FAIL sparse.rsp[%0d]: got v=%b id=%0d sum=%0d want v=1 id=%0d sum=%0d",
                         c, rsp_valid, rsp_id, rsp_sum, exp_id[c], 20 + exp_id[c]);
            end
            step();
        end
    endtask

    task automatic test_midflight_reset();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        vectors++;
        if ({rsp_valid, rsp_id} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL mid.inflight: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum} !== '0) begin
            errors++;
            $display("FAIL mid.async_clear: got v=%b id=%0d sum=%h want all zero",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid.stale[%0d]: got rsp_valid=%b want 0", c, rsp_valid);
            end
        end
        req_valid = 4'b1001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid.priority: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        step();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 35'd20}) begin
            errors++;
            $display("FAIL mid.rsp: got v=%b id=%0d sum=%0d want v=1 id=0 sum=20",
                     rsp_valid, rsp_id, rsp_sum);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_midflight_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one pipelined unsigned adder among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Internally it is a two-stage pipeline: operand register, then sum register. This matches the timing of the standalone registered adder benchmark.
- It sits between several operand producers and a single result consumer. Each result is tagged with the ID of the requester that produced the operands.

Parameters:
- ADDER_WIDTH, 34, operand width in bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of the requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i presents operands.
- req_ready  output  NUM_REQ  bit i: requester i is granted this cycle. One-hot or zero.
- req_a  input  NUM_REQ*ADDER_WIDTH  operand A; requester i occupies slice [i*W +: W].
- req_b  input  NUM_REQ*ADDER_WIDTH  operand B; same packing as req_a.
- rsp_valid  output  1  rsp_sum and rsp_id are valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_sum  output  ADDER_WIDTH+1  a+b, unsigned; the MSB is the carry-out.
- rsp_id  output  ID_WIDTH  index of the requester that issued the operands.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - Stage-1 valid=0; stage-1 operands and ID=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset asserted mid-operation discards all in-flight transactions. No response is emitted for them.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - While stall=1: req_ready=0, and both stages and the pointer hold their values.
  - rsp_valid, rsp_sum and rsp_id stay stable until accepted.
- Grant (combinational, only when stall=0):
  - Scan requesters last+1, last+2, ... modulo NUM_REQ.
  - The first one with req_valid=1 gets req_ready=1.
  - A handshake occurs when req_valid[i] & req_ready[i] are both high.
- Pointer:
  - last <= granted index on each handshake.
  - Unchanged when there is no grant.
- Stage 1, on a non-stall edge:
  - s1_valid <= any grant.
  - On a grant, s1_a, s1_b and s1_id capture the granted slice and its index.
  - With no grant, the operands may hold their old values (don't-care).
- Stage 2, on a non-stall edge:
  - rsp_valid <= s1_valid.
  - If s1_valid: rsp_sum <= {1'b0,s1_a} + {1'b0,s1_b} at full ADDER_WIDTH+1 width; rsp_id <= s1_id.
  - An accepted response with no new data clears rsp_valid on the following edge.
- Latency and throughput:
  - Handshake at edge N gives rsp_valid high after edge N+2 (2 cycles).
  - Throughput is 1 result per cycle with rsp_ready held high.
- Ordering: responses leave in grant order. No reordering, no drops, no duplicates.
- Fairness: with all requesters continuously valid and no stall, grants rotate 0,1,2,3,0,...
  - Any valid requester is granted within NUM_REQ non-stall cycles.
- Requesters may change operands or drop req_valid freely when not granted. Only the handshake cycle's data is used.
- Boundary conditions:
  - Overflow: the carry is captured in rsp_sum MSB; nothing saturates or wraps.
  - Simultaneous stall and new request: the stall wins and no grant is issued.
  - rsp_ready high while rsp_valid low: no effect.

Test Plan:
- Single requester: reset, then req_valid=0001 with a=5, b=7 at edge N. Required: req_ready=0001 in that cycle; after edge N+2, rsp_valid=1, rsp_sum=12, rsp_id=0.
- Overflow: a=b=2^34-1 from requester 2. Required: rsp_sum=35'h7FFFFFFFE, rsp_id=2.
- All four requesters valid continuously, rsp_ready=1, operands a=i, b=100. Required: grant order 0,1,2,3,0,1; rsp_id follows the same sequence; rsp_sum=100+id; one response per cycle after the 2-cycle fill.
- Backpressure: rsp_ready=0 for 5 cycles while requests are pending. Required: req_ready=0 throughout; rsp_valid, rsp_sum and rsp_id stay stable; no response is lost when rsp_ready returns to 1, and the order is preserved.
- Sparse requests: requesters 1 and 3 toggle valid; after a grant to 3, requesters 0 and 1 both go valid. Required: 0 is granted first (pointer wraps 3→0), then 1.
- Mid-flight reset: rst_n is pulsed low between edges while two transactions are in flight. Required: rsp_valid drops to 0 immediately; no stale response appears after rst_n rises; the next request from requester 0 is granted first.
